distributor18: RTL and testbench

DISTRIBUTOR18 -- requirements
Module: distributor18

---
 rtl/distributor18_if.sv | 35 +++
 rtl/distributor18.sv | 74 +++++++
 tb/tb_distributor18.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/distributor18_if.sv
// Bundle of producer-side and consumer-side signals for the 1-to-8 distributor.
// The slave modport is the distributor; the master modport is its environment.
interface distributor18_if #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [2:0]       condition;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic [WIDTH-1:0] out3;
  logic [WIDTH-1:0] out4;
  logic [WIDTH-1:0] out5;
  logic [WIDTH-1:0] out6;
  logic [WIDTH-1:0] out7;
  logic [7:0]       out_valid;
  logic [7:0]       out_ready;
  logic             busy;
  logic [CNTW-1:0]  accept_cnt;

  modport slave (
    input  in_valid, in_data, condition, out_ready,
    output in_ready, out0, out1, out2, out3, out4, out5, out6, out7,
           out_valid, busy, accept_cnt
  );

  modport master (
    output in_valid, in_data, condition, out_ready,
    input  in_ready, out0, out1, out2, out3, out4, out5, out6, out7,
           out_valid, busy, accept_cnt
  );
endinterface

// File: rtl/distributor18.sv
// 1-to-8 distributor: each input word lands in the one-entry buffer of the
// channel picked by condition; every channel drains independently.
module distributor18 #(
  parameter int WIDTH = 32,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  distributor18_if.slave   bus
);

  logic [7:0]       valid_q;
  logic [7:0]       valid_d;
  logic [CNTW-1:0]  cnt_q;
  logic [CNTW-1:0]  cnt_d;
  logic [7:0]       sel;
  logic [7:0]       drain;
  logic             accept;
  logic [WIDTH-1:0] chan_data [8];

  assign sel = 8'd1 << bus.condition;

  // A full channel still accepts when it is draining on the same edge.
  assign bus.in_ready = rst_n & (~valid_q[bus.condition] | bus.out_ready[bus.condition]);
  assign accept       = bus.in_valid & bus.in_ready;
  assign drain        = valid_q & bus.out_ready;

  always_comb begin
    valid_d = valid_q & ~drain;
    cnt_d   = cnt_q;
    if (accept) begin
      valid_d = valid_d | sel;
      cnt_d   = cnt_q + {{(CNTW-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_chan
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    // Data only moves on an accept to this channel; draining leaves it intact.
    assign data_d = (accept && sel[gi]) ? bus.in_data : data_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) data_q <= '0;
      else        data_q <= data_d;
    end

    assign chan_data[gi] = data_q;
  end

  assign bus.out0       = chan_data[0];
  assign bus.out1       = chan_data[1];
  assign bus.out2       = chan_data[2];
  assign bus.out3       = chan_data[3];
  assign bus.out4       = chan_data[4];
  assign bus.out5       = chan_data[5];
  assign bus.out6       = chan_data[6];
  assign bus.out7       = chan_data[7];
  assign bus.out_valid  = valid_q;
  assign bus.busy       = |valid_q;
  assign bus.accept_cnt = cnt_q;

endmodule

// File: tb/tb_distributor18.sv
// Directed bench for distributor18: stimulus pushes expected words per channel,
// a negedge monitor pops and compares them whenever a channel drains.
module tb_distributor18;
  localparam int WIDTH = 32;
  localparam int CNTW  = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [CNTW-1:0]  exp_cnt;
  logic [WIDTH-1:0] exp_q [8][$];

  distributor18_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus_if ();

  distributor18 #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] chan_out(input int i);
    case (i)
      0: chan_out = bus_if.out0;
      1: chan_out = bus_if.out1;
      2: chan_out = bus_if.out2;
      3: chan_out = bus_if.out3;
      4: chan_out = bus_if.out4;
      5: chan_out = bus_if.out5;
      6: chan_out = bus_if.out6;
      default: chan_out = bus_if.out7;
    endcase
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called right after a rising edge (+1); leaves time at the next rising edge +1.
  task automatic drive(input logic v, input logic [2:0] c, input logic [WIDTH-1:0] d,
                       input logic [7:0] rdy, input logic exp_acc);
    bus_if.in_valid  = v;
    bus_if.condition = c;
    bus_if.in_data   = d;
    bus_if.out_ready = rdy;
    #1;
    if (v) chk("in_ready", {63'd0, bus_if.in_ready}, {63'd0, exp_acc});
    if (exp_acc) begin
      exp_q[c].push_back(d);
      exp_cnt = exp_cnt + 1'b1;
    end
    $display("txn: valid=%0b cond=%0d data=%h out_ready=%h expect_accept=%0b",
             v, c, d, rdy, exp_acc);
    @(posedge clk);
    #1;
    chk("accept_cnt", {60'd0, bus_if.accept_cnt}, {60'd0, exp_cnt});
  endtask

  // Monitor: a channel with valid & ready at negedge hands its word over at the next edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 8; i++) begin
        if (bus_if.out_valid[i] && bus_if.out_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            chk("drain_unexpected", {63'd0, 1'b1}, 64'd0);
          end else begin
            logic [WIDTH-1:0] w;
            w = exp_q[i].pop_front();
            $display("drain: ch=%0d data=%h", i, chan_out(i));
            chk("drain_data", {32'd0, chan_out(i)}, {32'd0, w});
          end
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    exp_cnt = '0;
    rst_n = 1'b0;
    bus_if.in_valid  = 1'b1;
    bus_if.condition = 3'd0;
    bus_if.in_data   = 32'h12345678;
    bus_if.out_ready = 8'h00;

    // Reset state
    #12;
    chk("rst_out_valid", {56'd0, bus_if.out_valid}, 64'd0);
    chk("rst_busy", {63'd0, bus_if.busy}, 64'd0);
    chk("rst_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
    chk("rst_cnt", {60'd0, bus_if.accept_cnt}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    // First accept on first edge after release
    drive(1'b1, 3'd5, 32'hDEADBEEF, 8'h00, 1'b1);
    chk("out5_first", {32'd0, bus_if.out5}, 64'hDEADBEEF);
    chk("out_valid_20", {56'd0, bus_if.out_valid}, 64'h20);
    chk("busy_set", {63'd0, bus_if.busy}, 64'd1);
    chk("cnt_1", {60'd0, bus_if.accept_cnt}, 64'd1);

    // Full channel blocks only while selected
    drive(1'b1, 3'd5, 32'hCAFE0001, 8'h00, 1'b0);
    chk("out5_held", {32'd0, bus_if.out5}, 64'hDEADBEEF);
    drive(1'b1, 3'd2, 32'h22222222, 8'h00, 1'b1);
    chk("out2", {32'd0, bus_if.out2}, 64'h22222222);
    chk("out_valid_24", {56'd0, bus_if.out_valid}, 64'h24);

    // Drain and refill same channel, then streaming
    drive(1'b1, 3'd3, 32'h00000033, 8'h00, 1'b1);
    drive(1'b1, 3'd3, 32'h00000011, 8'h08, 1'b1);
    chk("out3_refill", {32'd0, bus_if.out3}, 64'h11);
    chk("out_valid3_kept", {63'd0, bus_if.out_valid[3]}, 64'd1);
    for (int k = 0; k < 4; k++)
      drive(1'b1, 3'd3, 32'h40 + k, 8'h08, 1'b1);
    chk("cnt_8", {60'd0, bus_if.accept_cnt}, 64'd8);
    chk("out3_stream", {32'd0, bus_if.out3}, 64'h43);

    // Drain subset, data retained after drain
    drive(1'b1, 3'd0, 32'h000000A0, 8'h00, 1'b1);
    drive(1'b1, 3'd1, 32'h000000A1, 8'h00, 1'b1);
    drive(1'b1, 3'd7, 32'h000000A7, 8'h00, 1'b1);
    drive(1'b0, 3'd0, 32'h0, 8'h2C, 1'b0);
    chk("out_valid_83", {56'd0, bus_if.out_valid}, 64'h83);
    drive(1'b0, 3'd0, 32'h0, 8'h83, 1'b0);
    chk("drained_valid", {56'd0, bus_if.out_valid}, 64'd0);
    chk("drained_busy", {63'd0, bus_if.busy}, 64'd0);
    chk("out0_kept", {32'd0, bus_if.out0}, 64'hA0);
    chk("out1_kept", {32'd0, bus_if.out1}, 64'hA1);
    chk("out7_kept", {32'd0, bus_if.out7}, 64'hA7);

    // out_ready on empty channels does nothing
    drive(1'b0, 3'd0, 32'h0, 8'hFF, 1'b0);
    chk("empty_ready_valid", {56'd0, bus_if.out_valid}, 64'd0);
    chk("empty_ready_out0", {32'd0, bus_if.out0}, 64'hA0);

    // Multiple drains plus accept on another channel in one cycle
    drive(1'b1, 3'd4, 32'h000000B4, 8'h00, 1'b1);
    drive(1'b1, 3'd6, 32'h000000B6, 8'h00, 1'b1);
    drive(1'b1, 3'd0, 32'h000000C0, 8'h50, 1'b1);
    chk("mixed_valid", {56'd0, bus_if.out_valid}, 64'h01);
    chk("mixed_out0", {32'd0, bus_if.out0}, 64'hC0);

    // Counter wrap (14 accepts so far)
    drive(1'b1, 3'd1, 32'h000000D1, 8'h02, 1'b1);
    chk("cnt_all_ones", {60'd0, bus_if.accept_cnt}, 64'hF);
    drive(1'b1, 3'd1, 32'h000000D2, 8'h02, 1'b1);
    chk("cnt_wrap", {60'd0, bus_if.accept_cnt}, 64'h0);

    // Asynchronous reset mid-transfer
    drive(1'b1, 3'd2, 32'h000000D3, 8'h00, 1'b1);
    bus_if.in_valid  = 1'b1;
    bus_if.condition = 3'd3;
    bus_if.out_ready = 8'h00;
    #2 rst_n = 1'b0;
    for (int i = 0; i < 8; i++) exp_q[i].delete();
    exp_cnt = '0;
    #1;
    chk("arst_valid", {56'd0, bus_if.out_valid}, 64'd0);
    chk("arst_busy", {63'd0, bus_if.busy}, 64'd0);
    chk("arst_in_ready", {63'd0, bus_if.in_ready}, 64'd0);
    chk("arst_cnt", {60'd0, bus_if.accept_cnt}, 64'd0);
    chk("arst_out0", {32'd0, bus_if.out0}, 64'd0);
    chk("arst_out2", {32'd0, bus_if.out2}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    drive(1'b1, 3'd6, 32'h000000E6, 8'h00, 1'b1);
    chk("post_rst_out6", {32'd0, bus_if.out6}, 64'hE6);
    chk("post_rst_valid", {56'd0, bus_if.out_valid}, 64'h40);

    // Final drain; every expected word must have been delivered
    drive(1'b0, 3'd0, 32'h0, 8'hFF, 1'b0);
    @(negedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      chk("queue_empty", 64'(exp_q[i].size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
